// File: rtl/ttd_frame_averager.sv
// ttd_frame_averager: consumes TTD conversion frames, validates the comparator
// crossing of each frame, averages 2^LOG2_N captured codes with rounding and
// queues the results in a small valid/ready FIFO toward the readout logic.
module ttd_frame_averager #(
  parameter int LOG2_N      = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       rst_cap,
  input  logic       cmp_in,
  input  logic [7:0] sample_in,
  output logic [7:0] out_data,
  output logic       out_ovr,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow
);

  localparam int N     = 1 << LOG2_N;
  localparam int ACC_W = 8 + LOG2_N;
  localparam int CNT_W = LOG2_N + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [ACC_W:0]   HALF     = (ACC_W+1)'(N / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W:0]   PTR_ONE  = (PTR_W+1)'(1);

  // Round-half-up average of a full window; the sum of N codes plus N/2
  // shifted right by LOG2_N never exceeds 255, so plain truncation is safe.
  function automatic logic [7:0] round_avg(input logic [ACC_W-1:0] a);
    logic [ACC_W:0] s;
    s = {1'b0, a} + HALF;
    return 8'(s >> LOG2_N);
  endfunction

  logic [SYNC_STAGES-1:0] cmp_sync;
  logic                   cmp_prev;
  logic                   cmp_rise;
  logic                   rst_cap_q;
  logic                   vld_p0;
  logic                   hit;
  logic                   primed;
  logic                   vld_p1;
  logic [7:0]             smp_p1;
  logic                   ovr_p1;
  logic [ACC_W-1:0]       acc_p2;
  logic [ACC_W-1:0]       acc_sum;
  logic [CNT_W-1:0]       cnt_p2;
  logic                   wovr_p2;
  logic                   win_last;
  logic                   push;
  logic [7:0]             push_data;
  logic                   push_ovr;

  logic [8:0]             mem [FIFO_DEPTH];
  logic [PTR_W:0]         wr_ptr;
  logic [PTR_W:0]         rd_ptr;
  logic                   full;
  logic                   empty;
  logic                   pop;
  logic                   wr_en;

  assign cmp_rise = cmp_sync[SYNC_STAGES-1] & ~cmp_prev;

  // Synchronise the asynchronous comparator and keep its previous value for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_sync <= '0;
      cmp_prev <= 1'b0;
    end else begin
      cmp_sync <= {cmp_sync[SYNC_STAGES-2:0], cmp_in};
      cmp_prev <= cmp_sync[SYNC_STAGES-1];
    end
  end

  // ---- stage p0: frame end is the 0->1 transition of rst_cap ----
  // Register the cap-reset flag and flag the frame-end edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_cap_q <= 1'b1;
      vld_p0    <= 1'b0;
    end else begin
      rst_cap_q <= rst_cap;
      vld_p0    <= rst_cap & ~rst_cap_q;
    end
  end

  // Crossing flag: set by a synchronised rising edge during the ramp, cleared once consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit <= 1'b0;
    end else if (vld_p0) begin
      hit <= 1'b0;
    end else if (cmp_rise && !rst_cap) begin
      hit <= 1'b1;
    end
  end

  // ---- stage p1: frame qualification and sample capture ----
  // The first frame after reset or enable rise is partial: it only primes the block.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      vld_p1 <= 1'b0;
      primed <= 1'b0;
    end else begin
      vld_p1 <= vld_p0 & primed;
      if (vld_p0) begin
        primed <= 1'b1;
      end
    end
  end

  // Capture the code, or zero with the no-crossing flag when the comparator never fired.
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      smp_p1 <= hit ? sample_in : 8'h00;
      ovr_p1 <= ~hit;
    end
  end

  // ---- stage p2: accumulate and emit one rounded result per window ----
  assign acc_sum   = acc_p2 + ACC_W'(smp_p1);
  assign win_last  = (cnt_p2 == CNT_LAST);
  assign push      = vld_p1 & enable & win_last;
  assign push_data = round_avg(acc_sum);
  assign push_ovr  = wovr_p2 | ovr_p1;

  // Window accumulator; cleared when a window completes or the block is disabled.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      acc_p2  <= '0;
      cnt_p2  <= '0;
      wovr_p2 <= 1'b0;
    end else if (vld_p1) begin
      if (win_last) begin
        acc_p2  <= '0;
        cnt_p2  <= '0;
        wovr_p2 <= 1'b0;
      end else begin
        acc_p2  <= acc_sum;
        cnt_p2  <= cnt_p2 + CNT_ONE;
        wovr_p2 <= push_ovr;
      end
    end
  end

  // ---- output FIFO ----
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign wr_en     = push & (~full | pop);
  assign {out_data, out_ovr} = mem[rd_ptr[PTR_W-1:0]];

  // FIFO storage and pointers; storage is cleared on reset so outputs read zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr[PTR_W-1:0]] <= {push_data, push_ovr};
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
